// File: rtl/armleocpu_plic_target_arbiter_pkg.sv
// Shared types for the sequential PLIC target arbiter.
package armleocpu_plic_target_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/armleocpu_plic_matrix_cell.sv
// One link of the max-priority chain: takes over the running (prio, id)
// only when its own priority is strictly greater, so ties keep the lower ID.
module armleocpu_plic_matrix_cell #(
    parameter int PRIORITY_WIDTH = 3,
    parameter int ID_WIDTH       = 5
) (
    input  logic [PRIORITY_WIDTH-1:0] calc_prio,
    input  logic [ID_WIDTH-1:0]       id,
    input  logic [PRIORITY_WIDTH-1:0] in_prio,
    input  logic [ID_WIDTH-1:0]       in_id,
    output logic [PRIORITY_WIDTH-1:0] out_prio,
    output logic [ID_WIDTH-1:0]       out_id
);

    always_comb begin
        out_prio = in_prio;
        out_id   = in_id;
        if (calc_prio > in_prio) begin
            out_prio = calc_prio;
            out_id   = id;
        end
    end

endmodule

// File: rtl/armleocpu_plic_target_arbiter.sv
// Sequential max-priority finder for one PLIC target context: LANES cells per
// clock fold into a registered running maximum until every source has been seen.
//
// state | meaning
// IDLE  | waiting for scan_start (left unconditionally when CONTINUOUS)
// SCAN  | one group of LANES sources folded into the accumulator per clock
module armleocpu_plic_target_arbiter
    import armleocpu_plic_target_arbiter_pkg::*;
#(
    parameter int SOURCES        = 32,
    parameter int PRIORITY_WIDTH = 3,
    parameter int LANES          = 4,
    parameter bit CONTINUOUS     = 1'b0,
    localparam int ID_WIDTH      = $clog2(SOURCES)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [SOURCES-1:0]                pending,
    input  logic [SOURCES-1:0]                enable,
    input  logic [SOURCES*PRIORITY_WIDTH-1:0] priority_flat,
    input  logic [PRIORITY_WIDTH-1:0]         threshold,
    input  logic                              scan_start,
    output logic                              scan_busy,
    output logic                              result_valid,
    output logic [ID_WIDTH-1:0]               result_id,
    output logic [PRIORITY_WIDTH-1:0]         result_priority,
    output logic                              eip
);

    // One extra bit on base keeps base+lane from wrapping when SOURCES is a power of two.
    localparam int BASE_W = ID_WIDTH + 1;
    localparam int EXT    = 1 << BASE_W;

    arb_state_t state, state_next;
    logic group_en, group_last, last_group;

    logic [BASE_W-1:0]         base;
    logic [PRIORITY_WIDTH-1:0] acc_prio;
    logic [ID_WIDTH-1:0]       acc_id;

    logic [PRIORITY_WIDTH-1:0] calc_prio  [EXT];
    logic [PRIORITY_WIDTH-1:0] chain_prio [LANES+1];
    logic [ID_WIDTH-1:0]       chain_id   [LANES+1];
    logic [BASE_W-1:0]         lane_id    [LANES];

    // ID 0 is reserved; its bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{pending[0], enable[0], priority_flat[PRIORITY_WIDTH-1:0]};

    // Effective priority per ID, padded with zeros past SOURCES so lanes never index out of range.
    for (genvar i = 0; i < EXT; i++) begin : g_calc
        if (i > 0 && i < SOURCES) begin : g_src
            assign calc_prio[i] = (pending[i] && enable[i])
                                ? priority_flat[i*PRIORITY_WIDTH +: PRIORITY_WIDTH] : '0;
        end else begin : g_none
            assign calc_prio[i] = '0;
        end
    end

    assign chain_prio[0] = acc_prio;
    assign chain_id[0]   = acc_id;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_id[l] = base + BASE_W'(l);

        armleocpu_plic_matrix_cell #(
            .PRIORITY_WIDTH (PRIORITY_WIDTH),
            .ID_WIDTH       (ID_WIDTH)
        ) u_cell (
            .calc_prio (calc_prio[lane_id[l]]),
            .id        (lane_id[l][ID_WIDTH-1:0]),
            .in_prio   (chain_prio[l]),
            .in_id     (chain_id[l]),
            .out_prio  (chain_prio[l+1]),
            .out_id    (chain_id[l+1])
        );
    end

    assign last_group = (int'(base) + LANES) >= SOURCES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (scan_start || CONTINUOUS) state_next = ST_SCAN;
            ST_SCAN: if (last_group && !CONTINUOUS) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        scan_busy  = (state == ST_SCAN);
        group_en   = (state == ST_SCAN);
        group_last = (state == ST_SCAN) && last_group;
    end

    // Accumulator is held cleared while idle, so every scan starts from (0, 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base            <= '0;
            acc_prio        <= '0;
            acc_id          <= '0;
            result_valid    <= 1'b0;
            result_id       <= '0;
            result_priority <= '0;
            eip             <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (!group_en || group_last) begin
                base     <= '0;
                acc_prio <= '0;
                acc_id   <= '0;
            end else begin
                base     <= base + BASE_W'(LANES);
                acc_prio <= chain_prio[LANES];
                acc_id   <= chain_id[LANES];
            end
            if (group_last) begin
                result_id       <= chain_id[LANES];
                result_priority <= chain_prio[LANES];
                eip             <= (chain_prio[LANES] > threshold);
                result_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_plic_target_arbiter.sv
// Bench for the sequential PLIC target arbiter: vector table plus scoreboard,
// with hand sequences for busy, live sampling, abort and continuous mode.
module tb_armleocpu_plic_target_arbiter;

    localparam int S   = 32;
    localparam int PW  = 3;
    localparam int L   = 4;
    localparam int G   = 8;
    localparam int IW  = 5;
    localparam int S2  = 33;
    localparam int L2  = 5;
    localparam int G2  = 7;
    localparam int IW2 = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;

    logic [S-1:0]    pending = '0;
    logic [S-1:0]    enable = '0;
    logic [S*PW-1:0] priority_flat = '0;
    logic [PW-1:0]   threshold = '0;
    logic            scan_start = 1'b0;
    logic            scan_busy, result_valid, eip;
    logic [IW-1:0]   result_id;
    logic [PW-1:0]   result_priority;

    logic [S2-1:0]    pending2 = '0;
    logic [S2-1:0]    enable2 = '0;
    logic [S2*PW-1:0] priority_flat2 = '0;
    logic [PW-1:0]    threshold2 = '0;
    logic             scan_start2 = 1'b0;
    logic             scan_busy2, result_valid2, eip2;
    logic [IW2-1:0]   result_id2;
    logic [PW-1:0]    result_priority2;

    armleocpu_plic_target_arbiter #(
        .SOURCES(S), .PRIORITY_WIDTH(PW), .LANES(L), .CONTINUOUS(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pending(pending), .enable(enable),
        .priority_flat(priority_flat), .threshold(threshold), .scan_start(scan_start),
        .scan_busy(scan_busy), .result_valid(result_valid), .result_id(result_id),
        .result_priority(result_priority), .eip(eip)
    );

    armleocpu_plic_target_arbiter #(
        .SOURCES(S2), .PRIORITY_WIDTH(PW), .LANES(L2), .CONTINUOUS(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .pending(pending2), .enable(enable2),
        .priority_flat(priority_flat2), .threshold(threshold2), .scan_start(scan_start2),
        .scan_busy(scan_busy2), .result_valid(result_valid2), .result_id(result_id2),
        .result_priority(result_priority2), .eip(eip2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string         name;
        logic [IW-1:0] id;
        logic [PW-1:0] prio;
        logic          eip;
        int            cyc;
    } exp_t;

    typedef struct {
        string           name;
        logic [S-1:0]    p;
        logic [S-1:0]    en;
        logic [S*PW-1:0] pr;
        logic [PW-1:0]   thr;
        logic [IW-1:0]   id;
        logic [PW-1:0]   mp;
        logic            e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   last_id = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding scan.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && result_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_id"}, result_id, e.id);
                chk({e.name, "_prio"}, result_priority, e.prio);
                chk({e.name, "_eip"}, eip, e.eip);
                chk({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    // Reference: flat scan over all IDs, strict compare so lower IDs win ties.
    function automatic void model(input logic [S-1:0] p, input logic [S-1:0] en,
                                  input logic [S*PW-1:0] pr, input logic [PW-1:0] thr,
                                  output logic [IW-1:0] id, output logic [PW-1:0] mp,
                                  output logic e);
        logic [PW-1:0] v;
        id = '0;
        mp = '0;
        for (int i = 1; i < S; i++) begin
            v = pr[i*PW +: PW];
            if (p[i] && en[i] && v > mp) begin
                mp = v;
                id = IW'(i);
            end
        end
        e = (mp > thr);
    endfunction

    function automatic logic [S*PW-1:0] pf(input int a, input int va, input int b, input int vb);
        logic [S*PW-1:0] f;
        f = '0;
        f[a*PW +: PW] = PW'(va);
        f[b*PW +: PW] = PW'(vb);
        return f;
    endfunction

    function automatic vec_t mk(input string nm, input logic [S-1:0] p, input logic [S-1:0] en,
                                input logic [S*PW-1:0] pr, input int thr, input int id,
                                input int mp, input bit e);
        vec_t v;
        v.name = nm; v.p = p; v.en = en; v.pr = pr; v.thr = PW'(thr);
        v.id = IW'(id); v.mp = PW'(mp); v.e = e;
        return v;
    endfunction

    task automatic push_exp(input string nm, input int id, input int mp, input bit e);
        exp_t x;
        x.name = nm; x.id = IW'(id); x.prio = PW'(mp); x.eip = e; x.cyc = cyc + 1 + G;
        sb.push_back(x);
        last_id = id;
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        while (sb.size() != 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout_outstanding", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_valid(input int max_cyc);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!result_valid && k < max_cyc);
        if (!result_valid) chk("wait_valid_timeout", 0, 1);
    endtask

    // Called at a negedge; scan_start is sampled at the following posedge.
    task automatic start_scan(input string nm, input int id, input int mp, input bit e);
        scan_start = 1'b1;
        push_exp(nm, id, mp, e);
        @(negedge clk);
        scan_start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        pending = v.p; enable = v.en; priority_flat = v.pr; threshold = v.thr;
        start_scan(v.name, v.id, v.mp, v.e);
        drain(G + 6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            v;
        logic [S*PW-1:0] tmp;
        int              snap, last, pulses, k, c0;

        vt.push_back(mk("single",    32'h0000_0200, 32'h0000_0200, pf(9,5,0,0),  3,  9, 5, 1));
        vt.push_back(mk("single_thr",32'h0000_0200, 32'h0000_0200, pf(9,5,0,0),  5,  9, 5, 0));
        vt.push_back(mk("tie",       32'h0020_0040, 32'h0020_0040, pf(6,4,21,4), 0,  6, 4, 1));
        vt.push_back(mk("raise",     32'h0020_0040, 32'h0020_0040, pf(6,4,21,5), 0, 21, 5, 1));
        vt.push_back(mk("mask",      32'h0000_1001, 32'h0000_0001, pf(12,7,0,7), 0,  0, 0, 0));
        vt.push_back(mk("all7",      '1,            '1,            {S{3'd7}},    7,  1, 7, 0));
        vt.push_back(mk("last_id",   32'hC000_0000, 32'h8000_0000, pf(31,1,30,6),0, 31, 1, 1));
        vt.push_back(mk("grp_tie",   32'h0000_0018, 32'h0000_0018, pf(3,2,4,2),  1,  3, 2, 1));
        vt.push_back(mk("grp_win",   32'h0000_0018, 32'h0000_0018, pf(3,2,4,3),  3,  4, 3, 0));
        vt.push_back(mk("none",      '0,            '1,            {S{3'd7}},    0,  0, 0, 0));
        for (int r = 0; r < 6; r++) begin
            v.name = $sformatf("rand%0d", r);
            v.p = $urandom;
            v.en = $urandom;
            for (int i = 0; i < S; i++) v.pr[i*PW +: PW] = PW'($urandom_range(0, 7));
            v.thr = PW'($urandom_range(0, 7));
            model(v.p, v.en, v.pr, v.thr, v.id, v.mp, v.e);
            vt.push_back(v);
        end

        // Reset held with scan_start high: nothing may start or report.
        scan_start = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_busy", scan_busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_id", result_id, 0);
        chk("rst_prio", result_priority, 0);
        chk("rst_eip", eip, 0);
        scan_start = 1'b0;
        rst_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i]);

        // Live sampling: ID 2 changes after its group, ID 20 before its group.
        @(negedge clk);
        tmp = pf(9, 5, 2, 7);
        tmp[20*PW +: PW] = 3'd6;
        pending = 32'h0000_0200; enable = 32'h0010_0204; priority_flat = tmp; threshold = 3'd3;
        start_scan("live", 20, 6, 1);
        repeat (3) @(negedge clk);
        pending = 32'h0010_0204;
        wait_valid(G + 6);
        start_scan("live_next", 2, 7, 1);
        drain(G + 6);

        // scan_start held through the scan must yield exactly one result.
        @(negedge clk);
        pending = 32'h0000_0200; enable = 32'h0000_0200; priority_flat = pf(9,5,0,0); threshold = 3'd3;
        snap = n_valid;
        scan_start = 1'b1;
        k = last_id;
        push_exp("busy", 9, 5, 1);
        repeat (2) @(negedge clk);
        chk("busy_flag", scan_busy, 1);
        chk("busy_result_hold", result_id, k);
        repeat (3) @(negedge clk);
        scan_start = 1'b0;
        drain(G + 6);
        repeat (12) @(negedge clk);
        chk("busy_single_pulse", n_valid - snap, 1);

        // Reset in the 4th scan cycle aborts with no result.
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", scan_busy, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_id", result_id, 0);
        chk("abort_prio", result_priority, 0);
        chk("abort_eip", eip, 0);
        snap = n_valid;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_result", n_valid - snap, 0);
        chk("abort_idle", scan_busy, 0);
        run_vec(vt[2]);

        // Continuous mode, 33 sources over 5 lanes: partial last group holds the winner.
        pending2 = '0; pending2[5] = 1'b1; pending2[32] = 1'b1;
        enable2 = '1;
        priority_flat2 = '0;
        priority_flat2[5*PW +: PW] = 3'd6;
        priority_flat2[32*PW +: PW] = 3'd7;
        threshold2 = 3'd6;
        @(negedge clk);
        c0 = cyc;
        rst2_n = 1'b1;
        last = -1; pulses = 0; k = 0;
        while (pulses < 5 && k < 60) begin
            @(negedge clk);
            k++;
            chk("cont_busy", scan_busy2, 1);
            if (result_valid2) begin
                chk("cont_id", result_id2, 32);
                chk("cont_prio", result_priority2, 7);
                chk("cont_eip", eip2, 1);
                if (last < 0) chk("cont_first_latency", cyc - c0, 1 + G2);
                else chk("cont_period", cyc - last, G2);
                last = cyc;
                pulses++;
            end
        end
        chk("cont_pulses", pulses, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
